axi2mem_rd_channel_gen: RTL and testbench

// - Parametrised AXI4 read-channel front end for axi2mem. Converts AR bursts into per-beat

---
 rtl/axi2mem_rd_channel_gen.sv | 217 +++++++++++++++++++++
 tb/tb_axi2mem_rd_channel_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_rd_channel_gen.sv
// ---------------------------------------------------------------------------
// axi2mem_rd_channel_gen
//
// AXI4 read-channel front end for axi2mem. Each accepted AR burst is split
// into per-beat commands that go out on NB_PORTS 32-bit memory command lanes
// (lane k carries beat address + 4*k). Returned memory beats are passed
// straight through to R. The ID of every accepted burst is queued until its
// last R beat has been handshaken.
//
// Optional feature macro: AXI2MEM_RD_WRAP_EN
//   defined     : WRAP bursts (len 1/3/7/15) wrap inside their aligned window
//   not defined : WRAP and the reserved burst encoding are treated as INCR
//
// Ports
//   clk_i, rst_i                    clock (rising edge), sync reset (active high)
//   axi_slave_ar_*                  AXI AR channel (valid/addr/len/burst/id/ready)
//   axi_slave_r_*                   AXI R channel (valid/data/resp/last/id/user/ready)
//   trans_id_o/add_o/req_o/last_o   per-lane memory command outputs
//   trans_gnt_i                     per-lane command queue can accept
//   data_dat_i/last_i/gnt_i         returned memory beat
//   data_req_o                      pop the returned beat
// ---------------------------------------------------------------------------
module axi2mem_rd_channel_gen #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int TRANS_ID_WIDTH = 6,
    parameter int ID_FIFO_DEPTH  = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      axi_slave_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]                 axi_slave_ar_addr_i,
    input  logic [7:0]                                axi_slave_ar_len_i,
    input  logic [1:0]                                axi_slave_ar_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]                   axi_slave_ar_id_i,
    output logic                                      axi_slave_ar_ready_o,
    output logic                                      axi_slave_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]                 axi_slave_r_data_o,
    output logic [1:0]                                axi_slave_r_resp_o,
    output logic                                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]                   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0]                 axi_slave_r_user_o,
    input  logic                                      axi_slave_r_ready_i,
    output logic [(AXI_DATA_WIDTH/32)*TRANS_ID_WIDTH-1:0] trans_id_o,
    output logic [(AXI_DATA_WIDTH/32)*32-1:0]         trans_add_o,
    output logic [AXI_DATA_WIDTH/32-1:0]              trans_req_o,
    output logic [AXI_DATA_WIDTH/32-1:0]              trans_last_o,
    input  logic [AXI_DATA_WIDTH/32-1:0]              trans_gnt_i,
    input  logic [AXI_DATA_WIDTH-1:0]                 data_dat_i,
    input  logic                                      data_last_i,
    input  logic                                      data_gnt_i,
    output logic                                      data_req_o
);

    localparam int          NB_PORTS   = AXI_DATA_WIDTH / 32;
    localparam logic [31:0] BYTES      = 32'(AXI_DATA_WIDTH / 8);
    localparam logic [31:0] ALIGN_MASK = ~(BYTES - 32'd1);
    localparam int          PTR_W      = $clog2(ID_FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                        state_q, state_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [7:0]                    len_q, len_d;
    logic [31:0]                   base_q, base_d;
    logic [1:0]                    burst_q, burst_d;
    logic [AXI_ID_WIDTH-1:0]       id_q, id_d;

    logic [AXI_ID_WIDTH-1:0]       fifo_mem_q [ID_FIFO_DEPTH];
    logic [PTR_W:0]                wr_ptr_q, rd_ptr_q;
    logic                          fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic                          all_gnt;
    logic                          issue, last_beat;
    logic [31:0]                   beat_addr, run_addr, incr_addr;
    logic [AXI_ID_WIDTH-1:0]       beat_id;
    logic [TRANS_ID_WIDTH-1:0]     lane_id;
    logic                          r_valid;

    assign all_gnt = &trans_gnt_i;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // ---------------- beat address for RUN beats ----------------
    assign incr_addr = base_q + 32'(cnt_q) * BYTES;

`ifdef AXI2MEM_RD_WRAP_EN
    logic        wrap_ok;
    logic [31:0] wrap_mask;
    assign wrap_ok   = (burst_q == 2'b10) &&
                       ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
    assign wrap_mask = (32'(len_q) + 32'd1) * BYTES - 32'd1;
    assign run_addr  = (burst_q == 2'b00) ? base_q :
                       wrap_ok ? ((base_q & ~wrap_mask) | (incr_addr & wrap_mask)) :
                       incr_addr;
`else
    assign run_addr  = (burst_q == 2'b00) ? base_q : incr_addr;
`endif

    // ---------------- FSM next state / command outputs ----------------
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        len_d                = len_q;
        base_d               = base_q;
        burst_d              = burst_q;
        id_d                 = id_q;
        axi_slave_ar_ready_o = 1'b0;
        fifo_push            = 1'b0;
        issue                = 1'b0;
        last_beat            = 1'b0;
        beat_addr            = 32'd0;
        beat_id              = '0;

        case (state_q)
            IDLE: begin
                // Beat 0 goes out in the accept cycle, so AR needs every lane granted.
                axi_slave_ar_ready_o = axi_slave_ar_valid_i & all_gnt & ~fifo_full & ~rst_i;
                if (axi_slave_ar_ready_o) begin
                    issue     = 1'b1;
                    fifo_push = 1'b1;
                    beat_addr = 32'(axi_slave_ar_addr_i) & ALIGN_MASK;
                    beat_id   = axi_slave_ar_id_i;
                    base_d    = beat_addr;
                    len_d     = axi_slave_ar_len_i;
                    burst_d   = axi_slave_ar_burst_i;
                    id_d      = axi_slave_ar_id_i;
                    if (axi_slave_ar_len_i == 8'd0) begin
                        last_beat = 1'b1;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                beat_id = id_q;
                if (all_gnt && !rst_i) begin
                    issue     = 1'b1;
                    beat_addr = run_addr;
                    if (cnt_q == len_q) begin
                        last_beat = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_id      = TRANS_ID_WIDTH'(beat_id);
    assign trans_id_o   = {NB_PORTS{lane_id}};
    assign trans_req_o  = {NB_PORTS{issue}};
    assign trans_last_o = {NB_PORTS{issue & last_beat}};

    always_comb begin
        trans_add_o = '0;
        for (int k = 0; k < NB_PORTS; k++) begin
            trans_add_o[k*32 +: 32] = issue ? (beat_addr + 32'(4 * k)) : 32'd0;
        end
    end

    // ---------------- R path ----------------
    assign r_valid             = data_gnt_i & ~rst_i;
    assign axi_slave_r_valid_o = r_valid;
    assign axi_slave_r_data_o  = data_dat_i;
    assign axi_slave_r_resp_o  = 2'b00;
    assign axi_slave_r_last_o  = data_last_i & r_valid;
    assign axi_slave_r_user_o  = '0;
    assign data_req_o          = r_valid & axi_slave_r_ready_i;
    assign fifo_pop            = data_req_o & data_last_i & ~fifo_empty;
    assign axi_slave_r_id_o    = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            len_q    <= 8'd0;
            base_q   <= 32'd0;
            burst_q  <= 2'b00;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            base_q   <= base_d;
            burst_q  <= burst_d;
            id_q     <= id_d;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the ID storage is not reset; the pointers alone define which
    // entries are valid, and r_id reads zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= axi_slave_ar_id_i;
        end
    end

endmodule

// File: tb/tb_axi2mem_rd_channel_gen.sv
// ---------------------------------------------------------------------------
// tb_axi2mem_rd_channel_gen
//
// Directed bench for axi2mem_rd_channel_gen with default parameters
// (64-bit data, 2 lanes, 8-byte beats, 4-deep ID FIFO). Inputs are driven
// 1 time unit after the rising edge and outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_axi2mem_rd_channel_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic [2:0]  ar_id;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        r_ready;
    logic [11:0] trans_id;
    logic [63:0] trans_add;
    logic [1:0]  trans_req;
    logic [1:0]  trans_last;
    logic [1:0]  trans_gnt;
    logic [63:0] data_dat;
    logic        data_last;
    logic        data_gnt;
    logic        data_req;

    int passes = 0;
    int total  = 0;

    axi2mem_rd_channel_gen dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .axi_slave_ar_valid_i (ar_valid),
        .axi_slave_ar_addr_i  (ar_addr),
        .axi_slave_ar_len_i   (ar_len),
        .axi_slave_ar_burst_i (ar_burst),
        .axi_slave_ar_id_i    (ar_id),
        .axi_slave_ar_ready_o (ar_ready),
        .axi_slave_r_valid_o  (r_valid),
        .axi_slave_r_data_o   (r_data),
        .axi_slave_r_resp_o   (r_resp),
        .axi_slave_r_last_o   (r_last),
        .axi_slave_r_id_o     (r_id),
        .axi_slave_r_user_o   (r_user),
        .axi_slave_r_ready_i  (r_ready),
        .trans_id_o           (trans_id),
        .trans_add_o          (trans_add),
        .trans_req_o          (trans_req),
        .trans_last_o         (trans_last),
        .trans_gnt_i          (trans_gnt),
        .data_dat_i           (data_dat),
        .data_last_i          (data_last),
        .data_gnt_i           (data_gnt),
        .data_req_o           (data_req)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One issued beat: both lanes requested, lane0 = a, lane1 = a+4.
    task automatic check_beat(input string tag, input logic [31:0] a, input logic l);
        check({tag, "_req"}, 64'(trans_req), 64'h3);
        check({tag, "_add"}, trans_add, {a + 32'd4, a});
        check({tag, "_last"}, 64'(trans_last), l ? 64'h3 : 64'h0);
    endtask

    // Push one returned beat through R with r_ready high and check its ID.
    task automatic drain_one(input string tag, input logic [2:0] id);
        data_gnt = 1'b1; data_last = 1'b1; r_ready = 1'b1;
        #1;
        check({tag, "_rid"}, 64'(r_id), 64'(id));
        tick();
        data_gnt = 1'b0; data_last = 1'b0;
    endtask

    int          beats;
    int          last_cnt;
    int          last_at;
    logic [31:0] last_addr;
    logic [31:0] w2, w3;

    initial begin
        rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_burst = 2'b01;
        ar_id = '0; r_ready = 1'b0; trans_gnt = 2'b11; data_dat = '0;
        data_last = 1'b0; data_gnt = 1'b0;
        tick(); tick();

        // ---- reset state ----
        check("rst_ar_ready", 64'(ar_ready), 64'h0);
        check("rst_req", 64'(trans_req), 64'h0);
        rst = 1'b0;
        #1;
        check("idle_req", 64'(trans_req), 64'h0);
        check("idle_add", trans_add, 64'h0);
        check("idle_last", 64'(trans_last), 64'h0);
        check("idle_rvalid", 64'(r_valid), 64'h0);
        check("idle_dreq", 64'(data_req), 64'h0);
        check("idle_rid", 64'(r_id), 64'h0);

        // ---- single beat, unaligned address ----
        tick();
        ar_valid = 1'b1; ar_addr = 32'h1004; ar_len = 8'd0; ar_burst = 2'b01; ar_id = 3'd5;
        #1;
        check("t1_ar_ready", 64'(ar_ready), 64'h1);
        check_beat("t1_b0", 32'h1000, 1'b1);
        check("t1_tid", 64'(trans_id), 64'h145);
        tick();
        ar_valid = 1'b0;
        #1;
        check("t1_req_after", 64'(trans_req), 64'h0);
        data_gnt = 1'b1; data_last = 1'b1; r_ready = 1'b1; data_dat = 64'hDEADBEEF_01234567;
        #1;
        check("t1_rvalid", 64'(r_valid), 64'h1);
        check("t1_rid", 64'(r_id), 64'h5);
        check("t1_rlast", 64'(r_last), 64'h1);
        check("t1_dreq", 64'(data_req), 64'h1);
        check("t1_rdata", r_data, 64'hDEADBEEF_01234567);
        check("t1_rresp", 64'(r_resp), 64'h0);
        tick();
        data_gnt = 1'b0; data_last = 1'b0;
        #1;
        check("t1_rvalid_off", 64'(r_valid), 64'h0);
        check("t1_rid_empty", 64'(r_id), 64'h0);

        // ---- INCR len 3 with partial grant stall ----
        tick();
        ar_valid = 1'b1; ar_addr = 32'h2000; ar_len = 8'd3; ar_burst = 2'b01; ar_id = 3'd2;
        #1;
        check_beat("t2_b0", 32'h2000, 1'b0);
        tick();
        ar_valid = 1'b0; trans_gnt = 2'b01;
        #1;
        check("t2_stall1_req", 64'(trans_req), 64'h0);
        check("t2_stall1_arr", 64'(ar_ready), 64'h0);
        tick();
        check("t2_stall2_req", 64'(trans_req), 64'h0);
        tick();
        trans_gnt = 2'b11;
        #1;
        check_beat("t2_b1", 32'h2008, 1'b0);
        check("t2_tid", 64'(trans_id), 64'h082);
        tick();
        check_beat("t2_b2", 32'h2010, 1'b0);
        tick();
        check_beat("t2_b3", 32'h2018, 1'b1);
        tick();
        check("t2_idle_req", 64'(trans_req), 64'h0);
        data_gnt = 1'b1; data_last = 1'b0; r_ready = 1'b1;
        #1;
        check("t2_rid_mid", 64'(r_id), 64'h2);
        check("t2_rlast_mid", 64'(r_last), 64'h0);
        tick();
        drain_one("t2_end", 3'd2);

        // ---- FIXED len 2 ----
        tick();
        ar_valid = 1'b1; ar_addr = 32'h3008; ar_len = 8'd2; ar_burst = 2'b00; ar_id = 3'd3;
        #1;
        check_beat("t3_b0", 32'h3008, 1'b0);
        tick();
        ar_valid = 1'b0;
        #1;
        check_beat("t3_b1", 32'h3008, 1'b0);
        tick();
        check_beat("t3_b2", 32'h3008, 1'b1);
        tick();
        check("t3_idle_req", 64'(trans_req), 64'h0);
        drain_one("t3", 3'd3);

        // ---- INCR len 255 ----
        tick();
        ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd255; ar_burst = 2'b01; ar_id = 3'd4;
        #1;
        check_beat("t4_b0", 32'h0, 1'b0);
        beats = 1; last_cnt = 0; last_at = 0; last_addr = '0;
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (trans_req == 2'b11) begin
                beats++;
                if (trans_last == 2'b11) begin
                    last_cnt++;
                    last_at   = beats;
                    last_addr = trans_add[31:0];
                end
            end
            tick();
        end
        check("t4_beats", 64'(beats), 64'd256);
        check("t4_last_cnt", 64'(last_cnt), 64'd1);
        check("t4_last_at", 64'(last_at), 64'd256);
        check("t4_last_addr", 64'(last_addr), 64'h7F8);
        drain_one("t4", 3'd4);

        // ---- ID FIFO full / ordering ----
        r_ready = 1'b0;
        for (int id = 1; id <= 4; id++) begin
            tick();
            ar_valid = 1'b1; ar_addr = 32'(id) << 8; ar_len = 8'd0; ar_burst = 2'b01;
            ar_id = 3'(id);
            #1;
            check("t5_push_arr", 64'(ar_ready), 64'h1);
        end
        tick();
        ar_id = 3'd6; ar_addr = 32'h600;
        #1;
        check("t5_full_arr", 64'(ar_ready), 64'h0);
        check("t5_full_req", 64'(trans_req), 64'h0);
        data_gnt = 1'b1; data_last = 1'b1;
        #1;
        check("t5_rvalid", 64'(r_valid), 64'h1);
        check("t5_rid1", 64'(r_id), 64'h1);
        check("t5_dreq0", 64'(data_req), 64'h0);
        tick();
        check("t5_rvalid_hold", 64'(r_valid), 64'h1);
        check("t5_rid1_hold", 64'(r_id), 64'h1);
        r_ready = 1'b1;
        #1;
        check("t5_pop_full_arr", 64'(ar_ready), 64'h0);
        check("t5_dreq1", 64'(data_req), 64'h1);
        tick();
        check("t5_rid2", 64'(r_id), 64'h2);
        check("t5_push_pop_arr", 64'(ar_ready), 64'h1);
        tick();
        ar_valid = 1'b0;
        #1;
        check("t5_rid3", 64'(r_id), 64'h3);
        tick();
        check("t5_rid4", 64'(r_id), 64'h4);
        tick();
        check("t5_rid6", 64'(r_id), 64'h6);
        tick();
        data_gnt = 1'b0; data_last = 1'b0;
        #1;
        check("t5_empty_rid", 64'(r_id), 64'h0);

        // ---- WRAP len 3 ----
`ifdef AXI2MEM_RD_WRAP_EN
        w2 = 32'h4000; w3 = 32'h4008;
`else
        w2 = 32'h4020; w3 = 32'h4028;
`endif
        tick();
        ar_valid = 1'b1; ar_addr = 32'h4010; ar_len = 8'd3; ar_burst = 2'b10; ar_id = 3'd7;
        #1;
        check_beat("t6_b0", 32'h4010, 1'b0);
        tick();
        ar_valid = 1'b0;
        #1;
        check_beat("t6_b1", 32'h4018, 1'b0);
        tick();
        check_beat("t6_b2", w2, 1'b0);
        tick();
        check_beat("t6_b3", w3, 1'b1);
        tick();
        drain_one("t6", 3'd7);

        // ---- reset mid-RUN ----
        tick();
        ar_valid = 1'b1; ar_addr = 32'h5000; ar_len = 8'd3; ar_burst = 2'b01; ar_id = 3'd1;
        #1;
        check_beat("t7_b0", 32'h5000, 1'b0);
        tick();
        ar_valid = 1'b0; rst = 1'b1;
        #1;
        check("t7_rst_req", 64'(trans_req), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t7_post_req", 64'(trans_req), 64'h0);
        check("t7_post_last", 64'(trans_last), 64'h0);
        check("t7_post_add", trans_add, 64'h0);
        check("t7_post_arr", 64'(ar_ready), 64'h0);
        check("t7_post_rid", 64'(r_id), 64'h0);
        tick();
        ar_valid = 1'b1; ar_addr = 32'h6000; ar_len = 8'd0; ar_id = 3'd2;
        #1;
        check("t7_new_arr", 64'(ar_ready), 64'h1);
        check_beat("t7_new", 32'h6000, 1'b1);
        tick();
        ar_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
